// File: rtl/mem_responder.sv
// mem_responder: tagged load/store memory endpoint; load data and tag return MEM_LATENCY cycles after acceptance.
// Backpressure: response 0 rejects (busy tag, reset, scrub); MEM_RESPONDER_SCRUB_ON_RESET_EN zero-fills the array after reset.
package mem_responder_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } BUS_COMMAND;
endpackage

`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 16
`endif

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY  = 4,
    parameter int MEM_WORDS    = 1024,
    parameter int NUM_MEM_TAGS = `NUM_MEM_TAGS,
    parameter int DATA_SIZE    = `DATA_SIZE
) (
    input  logic                            clock,
    input  logic                            reset,
    input  BUS_COMMAND                      proc2mem_command,
    input  logic [31:0]                     proc2mem_addr,
    input  logic [DATA_SIZE-1:0]            proc2mem_data,
    output logic [$clog2(NUM_MEM_TAGS)-1:0] mem2proc_response,
    output logic [DATA_SIZE-1:0]            mem2proc_data,
    output logic [$clog2(NUM_MEM_TAGS)-1:0] mem2proc_tag
);
    localparam int TW = $clog2(NUM_MEM_TAGS);
    localparam int AW = $clog2(MEM_WORDS);

    logic [DATA_SIZE-1:0]    mem_q [MEM_WORDS];
    logic [TW-1:0]           next_tag_q, next_tag_d;
    logic [NUM_MEM_TAGS-1:0] busy_q, busy_d;
    logic [TW-1:0]           pipe_tag_q [MEM_LATENCY];
    logic [DATA_SIZE-1:0]    pipe_dat_q [MEM_LATENCY];

    logic                    ready;
    logic                    load_acc;
    logic                    store_acc;
    logic [AW-1:0]           widx;
    logic [DATA_SIZE-1:0]    rd_dat;
    logic [TW-1:0]           done_tag;
    logic                    unused_addr;

    assign widx        = proc2mem_addr[3 +: AW];
    assign unused_addr = ^{proc2mem_addr[2:0], proc2mem_addr[31:3+AW]};
    assign rd_dat      = mem_q[widx];
    assign done_tag    = pipe_tag_q[MEM_LATENCY-1];

    assign load_acc  = !reset && ready && (proc2mem_command == BUS_LOAD) && !busy_q[next_tag_q];
    assign store_acc = !reset && ready && (proc2mem_command == BUS_STORE);

    assign mem2proc_response = (load_acc || store_acc) ? next_tag_q : '0;
    assign mem2proc_tag      = done_tag;
    assign mem2proc_data     = pipe_dat_q[MEM_LATENCY-1];

`ifdef MEM_RESPONDER_SCRUB_ON_RESET_EN
    typedef enum logic {READY, SCRUB} state_t;

    state_t        state_q;
    logic [AW-1:0] scrub_cnt_q;

    assign ready = (state_q == READY);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
        end else begin
            case (state_q)
                SCRUB: begin
                    scrub_cnt_q <= scrub_cnt_q + AW'(1);
                    if (scrub_cnt_q == AW'(MEM_WORDS - 1)) begin
                        state_q <= READY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Scrub and store never overlap: stores are only accepted in READY.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == SCRUB)) begin
            mem_q[scrub_cnt_q] <= '0;
        end else if (store_acc) begin
            mem_q[widx] <= proc2mem_data;
        end
    end
`else
    assign ready = 1'b1;

    always_ff @(posedge clock) begin
        if (store_acc) begin
            mem_q[widx] <= proc2mem_data;
        end
    end
`endif

    always_comb begin
        next_tag_d = next_tag_q;
        if (load_acc || store_acc) begin
            next_tag_d = (next_tag_q == TW'(NUM_MEM_TAGS - 1)) ? TW'(1) : next_tag_q + TW'(1);
        end
        // A tag completing this cycle is never the one being accepted: acceptance needs it idle.
        busy_d = busy_q;
        if (done_tag != '0) begin
            busy_d[done_tag] = 1'b0;
        end
        if (load_acc) begin
            busy_d[next_tag_q] = 1'b1;
        end
    end

    // Tag 0 marks an empty stage; the last stage's data only moves with a real load so it holds when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag_q <= TW'(1);
            busy_q     <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
                pipe_dat_q[i] <= '0;
            end
        end else begin
            next_tag_q    <= next_tag_d;
            busy_q        <= busy_d;
            pipe_tag_q[0] <= load_acc ? next_tag_q : '0;
            if (load_acc) begin
                pipe_dat_q[0] <= rd_dat;
            end
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_tag_q[i] <= pipe_tag_q[i-1];
                if (pipe_tag_q[i-1] != '0) begin
                    pipe_dat_q[i] <= pipe_dat_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: default instance (latency 4, 16 tags) plus a 4-tag, latency-3 instance for the busy stall.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    BUS_COMMAND  cmd;
    logic [31:0] addr;
    logic [63:0] wdat;
    logic [3:0]  resp, otag;
    logic [63:0] odat;

    BUS_COMMAND  cmd_s;
    logic [31:0] addr_s;
    logic [63:0] wdat_s;
    logic [1:0]  resp_s, otag_s;
    logic [63:0] unused_odat_s;

    always #5 clock = ~clock;

    mem_responder dut (
        .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
        .proc2mem_data(wdat), .mem2proc_response(resp), .mem2proc_data(odat), .mem2proc_tag(otag)
    );

    mem_responder #(.MEM_LATENCY(3), .MEM_WORDS(64), .NUM_MEM_TAGS(4), .DATA_SIZE(64)) dut_s (
        .clock(clock), .reset(reset), .proc2mem_command(cmd_s), .proc2mem_addr(addr_s),
        .proc2mem_data(wdat_s), .mem2proc_response(resp_s), .mem2proc_data(unused_odat_s),
        .mem2proc_tag(otag_s)
    );

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] dat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [63:0] model [1024];
    logic [3:0]  exp_next;
    logic [3:0]  exp_resp;
    logic [63:0] last_dat;
    logic [3:0]  o_resp, o_tag;
    logic [63:0] o_dat;
    int          cyc = 0;
    int          scyc;
    int          errors = 0;
    int          checks = 0;

    // Drive one cycle's command at mid-cycle, sample outputs of that same cycle.
    task automatic step(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d);
        cmd  = c;
        addr = a;
        wdat = d;
        #1;
        o_resp = resp;
        o_tag  = otag;
        o_dat  = odat;
        scyc   = cyc;
        @(negedge clock);
        cyc++;
    endtask

    // Issue a command expected to be accepted; push the expected load completion to the scoreboard.
    task automatic issue(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d);
        logic [9:0] idx;
        idx      = a[12:3];
        exp_resp = (c == BUS_NONE) ? 4'd0 : exp_next;
        if (c == BUS_LOAD) sbq.push_back('{due: cyc + 4, tag: exp_next, dat: model[idx]});
        step(c, a, d);
        if (c == BUS_STORE) model[idx] = d;
        if (c != BUS_NONE) exp_next = (exp_next == 4'd15) ? 4'd1 : exp_next + 4'd1;
    endtask

`ifdef MEM_RESPONDER_SCRUB_ON_RESET_EN
    task automatic test_scrub_window(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step(BUS_LOAD, $urandom, 64'd0);
            if (o_resp !== 4'd0 || o_tag !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL scrub_window: %0d cycles with nonzero response/tag, required 0", bad);
        end
        for (int i = 0; i < 1024; i++) model[i] = 64'd0;
    endtask
`endif

    task automatic test_reset;
        reset = 1'b1;
        step(BUS_LOAD, 32'h40, 64'd0);
        checks++;
        if (o_resp !== 4'd0) begin errors++; $display("FAIL reset_resp_load got=%0d exp=0", o_resp); end
        step(BUS_STORE, 32'h40, 64'h1);
        checks++;
        if (o_resp !== 4'd0) begin errors++; $display("FAIL reset_resp_store got=%0d exp=0", o_resp); end
        reset = 1'b0;
        step(BUS_NONE, 32'h0, 64'd0);
        checks++;
        if (o_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", o_tag); end
        checks++;
        if (o_dat !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_dat); end
        exp_next = 4'd1;
        last_dat = 64'd0;
        sbq.delete();
`ifdef MEM_RESPONDER_SCRUB_ON_RESET_EN
        test_scrub_window(1023);
`endif
    endtask

    task automatic test_store_load;
        BUS_COMMAND  sc[8];
        logic [31:0] sa[8];
        logic [63:0] sd[8];
        for (int i = 0; i < 8; i++) begin sc[i] = BUS_NONE; sa[i] = 32'h0; sd[i] = 64'd0; end
        sc[0] = BUS_STORE; sa[0] = 32'h40; sd[0] = 64'hDEADBEEF_CAFEF00D;
        sc[1] = BUS_LOAD;  sa[1] = 32'h40;
        for (int i = 0; i < 8; i++) begin
            issue(sc[i], sa[i], sd[i]);
            if (sc[i] != BUS_NONE) begin
                checks++;
                if (o_resp !== exp_resp) begin errors++; $display("FAIL sl_resp cyc=%0d got=%0d exp=%0d", scyc, o_resp, exp_resp); end
            end
            if (o_tag !== 4'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL sl_spurious cyc=%0d tag=%0d exp none", scyc, o_tag);
                end else begin
                    e = sbq.pop_front();
                    last_dat = e.dat;
                    if (o_tag !== e.tag || o_dat !== e.dat || scyc != e.due) begin
                        errors++;
                        $display("FAIL sl_cmpl got cyc=%0d tag=%0d data=%h exp cyc=%0d tag=%0d data=%h", scyc, o_tag, o_dat, e.due, e.tag, e.dat);
                    end
                end
            end else begin
                checks++;
                if (o_dat !== last_dat) begin errors++; $display("FAIL sl_hold cyc=%0d data=%h exp=%h", scyc, o_dat, last_dat); end
            end
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL sl_missing pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_addr_wrap;
        BUS_COMMAND  sc[9];
        logic [31:0] sa[9];
        logic [63:0] sd[9];
        for (int i = 0; i < 9; i++) begin sc[i] = BUS_NONE; sa[i] = 32'h0; sd[i] = 64'd0; end
        sc[0] = BUS_STORE; sa[0] = 32'h40; sd[0] = 64'h01234567_89ABCDEF;
        sc[1] = BUS_LOAD;  sa[1] = 32'h40 + 32'd8 * 32'd1024 + 32'd5;
        sc[2] = BUS_LOAD;  sa[2] = 32'hFFFF_6047;
        for (int i = 0; i < 9; i++) begin
            issue(sc[i], sa[i], sd[i]);
            if (sc[i] != BUS_NONE) begin
                checks++;
                if (o_resp !== exp_resp) begin errors++; $display("FAIL wrap_resp cyc=%0d got=%0d exp=%0d", scyc, o_resp, exp_resp); end
            end
            if (o_tag !== 4'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL wrap_spurious cyc=%0d tag=%0d exp none", scyc, o_tag);
                end else begin
                    e = sbq.pop_front();
                    if (o_tag !== e.tag || o_dat !== e.dat || scyc != e.due) begin
                        errors++;
                        $display("FAIL wrap_cmpl got cyc=%0d tag=%0d data=%h exp cyc=%0d tag=%0d data=%h", scyc, o_tag, o_dat, e.due, e.tag, e.dat);
                    end
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL wrap_missing pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_inflight;
        BUS_COMMAND  sc[10];
        logic [31:0] sa[10];
        logic [63:0] sd[10];
        for (int i = 0; i < 10; i++) begin sc[i] = BUS_NONE; sa[i] = 32'h0; sd[i] = 64'd0; end
        sc[0] = BUS_STORE; sa[0] = 32'h80; sd[0] = 64'hAAAA_0000_1111_AAAA;
        sc[1] = BUS_LOAD;  sa[1] = 32'h80;
        sc[2] = BUS_STORE; sa[2] = 32'h80; sd[2] = 64'hBBBB_2222_3333_BBBB;
        sc[3] = BUS_LOAD;  sa[3] = 32'h80;
        for (int i = 0; i < 10; i++) begin
            issue(sc[i], sa[i], sd[i]);
            if (sc[i] != BUS_NONE) begin
                checks++;
                if (o_resp !== exp_resp) begin errors++; $display("FAIL infl_resp cyc=%0d got=%0d exp=%0d", scyc, o_resp, exp_resp); end
            end
            if (o_tag !== 4'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL infl_spurious cyc=%0d tag=%0d exp none", scyc, o_tag);
                end else begin
                    e = sbq.pop_front();
                    if (o_tag !== e.tag || o_dat !== e.dat || scyc != e.due) begin
                        errors++;
                        $display("FAIL infl_cmpl got cyc=%0d tag=%0d data=%h exp cyc=%0d tag=%0d data=%h", scyc, o_tag, o_dat, e.due, e.tag, e.dat);
                    end
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL infl_missing pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 46; i++) begin
            BUS_COMMAND c;
            c = (i < 20) ? BUS_STORE : (i < 40) ? BUS_LOAD : BUS_NONE;
            issue(c, 32'h1000 + 32'd8 * 32'(i % 20), {$urandom, $urandom});
            if (c != BUS_NONE) begin
                checks++;
                if (o_resp !== exp_resp || o_resp === 4'd0) begin errors++; $display("FAIL b2b_resp cyc=%0d got=%0d exp=%0d", scyc, o_resp, exp_resp); end
            end
            if (o_tag !== 4'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc=%0d tag=%0d exp none", scyc, o_tag);
                end else begin
                    e = sbq.pop_front();
                    if (o_tag !== e.tag || o_dat !== e.dat || scyc != e.due) begin
                        errors++;
                        $display("FAIL b2b_cmpl got cyc=%0d tag=%0d data=%h exp cyc=%0d tag=%0d data=%h", scyc, o_tag, o_dat, e.due, e.tag, e.dat);
                    end
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL b2b_missing pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    // Small pool: tags 1..3 in flight, 4th load waits for tag 1 to retire.
    task automatic test_busy_stall;
        logic [1:0] er[10];
        logic [1:0] et[10];
        er = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        et = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
        cmd = BUS_NONE;
        for (int i = 0; i < 10; i++) begin
            cmd_s  = (i < 5) ? BUS_LOAD : BUS_NONE;
            addr_s = 32'h8 * 32'(i);
            #1;
            checks++;
            if (resp_s !== er[i]) begin errors++; $display("FAIL stall_resp step=%0d got=%0d exp=%0d", i, resp_s, er[i]); end
            checks++;
            if (otag_s !== et[i]) begin errors++; $display("FAIL stall_tag step=%0d got=%0d exp=%0d", i, otag_s, et[i]); end
            @(negedge clock);
            cyc++;
        end
        cmd_s = BUS_NONE;
    endtask

    task automatic test_reset_midflight;
        int bad;
        for (int i = 0; i < 3; i++) begin
            issue(BUS_LOAD, 32'h40, 64'd0);
            checks++;
            if (o_resp !== exp_resp) begin errors++; $display("FAIL mid_resp cyc=%0d got=%0d exp=%0d", scyc, o_resp, exp_resp); end
        end
        reset = 1'b1;
        step(BUS_NONE, 32'h0, 64'd0);
        reset = 1'b0;
        sbq.delete();
        exp_next = 4'd1;
`ifdef MEM_RESPONDER_SCRUB_ON_RESET_EN
        test_scrub_window(1024);
        issue(BUS_LOAD, 32'h1234_5678, 64'd0);
`else
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(BUS_NONE, 32'h0, 64'd0);
            if (o_tag !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mid_dropped: %0d completions after reset, required 0", bad); end
        issue(BUS_LOAD, 32'h40, 64'd0);
`endif
        checks++;
        if (o_resp !== 4'd1) begin errors++; $display("FAIL mid_first_tag got=%0d exp=1", o_resp); end
        for (int i = 0; i < 6; i++) begin
            issue(BUS_NONE, 32'h0, 64'd0);
            if (o_tag !== 4'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL mid_spurious cyc=%0d tag=%0d exp none", scyc, o_tag);
                end else begin
                    e = sbq.pop_front();
                    if (o_tag !== e.tag || o_dat !== e.dat || scyc != e.due) begin
                        errors++;
                        $display("FAIL mid_cmpl got cyc=%0d tag=%0d data=%h exp cyc=%0d tag=%0d data=%h", scyc, o_tag, o_dat, e.due, e.tag, e.dat);
                    end
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL mid_missing pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    initial begin
        reset  = 1'b1;
        cmd    = BUS_NONE;
        addr   = 32'h0;
        wdat   = 64'd0;
        cmd_s  = BUS_NONE;
        addr_s = 32'h0;
        wdat_s = 64'd0;
        exp_next = 4'd1;
        last_dat = 64'd0;
        @(negedge clock);
        test_reset;
        test_store_load;
        test_addr_wrap;
        test_inflight;
        test_back_to_back;
        test_busy_stall;
        test_reset_midflight;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable main-memory responder: the memory-side end of the `BUS_COMMAND` / tag protocol used by the dcache and icache controllers. It accepts one load or store per cycle. Acceptance is signalled combinationally via `mem2proc_response`. Load data returns on `mem2proc_data` / `mem2proc_tag` a fixed number of cycles later. It replaces the behavioural memory model in synthesis and FPGA builds.

## Interface
Parameters:
- `MEM_LATENCY`, default 4: cycles from load acceptance to data return; legal range 1..(`NUM_MEM_TAGS`-1).
- `MEM_WORDS`, default 1024: number of `DATA_SIZE`-bit words in the array; power of two.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `proc2mem_command` in `BUS_COMMAND`: `BUS_NONE`, `BUS_LOAD` or `BUS_STORE`.
- `proc2mem_addr` in 32: byte address.
- `proc2mem_data` in `DATA_SIZE`: store data.
- `mem2proc_response` out $clog2(`NUM_MEM_TAGS`): combinational; nonzero means the command is accepted this cycle, 0 means rejected or idle.
- `mem2proc_data` out `DATA_SIZE`: registered load data.
- `mem2proc_tag` out $clog2(`NUM_MEM_TAGS`): registered; nonzero for exactly one cycle when the load with that tag completes.

## Operation
Addressing:
- Word index is `proc2mem_addr[3 +: $clog2(MEM_WORDS)]`.
- Bits [2:0] are ignored; upper bits are ignored, so out-of-range addresses wrap.

Tags and pointer:
- Valid tags are 1..`NUM_MEM_TAGS`-1; 0 means "no tag".
- `next_tag` is a round-robin pointer. It advances by 1 on each accepted command and wraps from `NUM_MEM_TAGS`-1 to 1.
- Each tag has a busy bit.

Load handling:
- A load is accepted iff `busy[next_tag]`=0 and the block is not in reset or scrub.
- On acceptance, `mem2proc_response` = `next_tag`.
- The array word is read in the acceptance cycle and captured with its tag into a `MEM_LATENCY`-deep return pipeline. A later store to the same word does not alter an in-flight load.
- `busy[tag]` is set on acceptance.
- If the load is not accepted, response = 0 and nothing changes; the requester retries.

Store handling:
- A store is always accepted outside reset or scrub, with response = `next_tag`.
- The word is written at the edge ending the cycle.
- The store does not set busy and never produces a completion.

`BUS_NONE`: response 0, no state change.

Return:
- Stage `MEM_LATENCY` drives `mem2proc_tag` and `mem2proc_data` and clears that tag's busy bit at the same edge.
- When no load completes, `mem2proc_tag` = 0 and `mem2proc_data` holds its previous value.
- Completions are in acceptance order, at most one per cycle.

Load and store in the same cycle are impossible: one command per cycle.

## Timing
- Load accepted in cycle T: `mem2proc_tag` and `mem2proc_data` are valid in cycle T+`MEM_LATENCY` only.
- The tag becomes reusable for acceptance from cycle T+`MEM_LATENCY`+1.
- A store in cycle T is visible to a load accepted in cycle T+1 or later.
- Sustained throughput is 1 command/cycle. A load stalls only if `next_tag` is still busy, which cannot happen when `NUM_MEM_TAGS`-1 > `MEM_LATENCY`.

Reset (synchronous):
- While `reset` = 1, `mem2proc_response` = 0 and no writes occur.
- The edge with `reset` = 1 clears every busy bit and the return pipeline and sets `next_tag` = 1.
- `mem2proc_tag` is 0 and `mem2proc_data` is 0 from the next cycle.
- Loads in flight at reset are dropped and never complete.
- Array contents are untouched, except as described under Configuration.

## Configuration
Macro: `MEM_RESPONDER_SCRUB_ON_RESET_EN`.

Defined:
- A two-state FSM, `READY`/`SCRUB`.
- Reset forces `SCRUB` with scrub counter = 0.
- Each `SCRUB` cycle writes zero to word[counter] and increments the counter.
- After word `MEM_WORDS`-1 the FSM goes to `READY`, so the scrub takes `MEM_WORDS` cycles after reset deasserts.
- In `SCRUB`, `mem2proc_response` = 0 for every command.
- Reassertion of reset mid-scrub restarts the scrub at word 0.

Undefined:
- No FSM; the block is ready in the first cycle after reset.
- Array contents after power-up or reset are unspecified.

## Test plan
All scenarios use `MEM_LATENCY`=4 and `NUM_MEM_TAGS`=16.
- Store then load, basic path:
  - Stimulus: `BUS_STORE` addr 0x40 data 0xDEADBEEF_CAFEF00D; next cycle `BUS_LOAD` 0x40.
  - Response: responses 1 then 2; in cycle +5 `mem2proc_tag`=2 and data = 0xDEADBEEF_CAFEF00D.
- Address wrap and offset ignore:
  - Stimulus: store to 0x40; load 0x40 + 8·`MEM_WORDS` + 5.
  - Response: same data returned.
- In-flight load isolation:
  - Stimulus: load 0x80 (old value A); next cycle store B to 0x80.
  - Response: completion returns A; a subsequent load returns B.
- Back-to-back loads and tag wrap:
  - Stimulus: 20 consecutive loads.
  - Response: responses 1..15, 1..5; completions in the same order one per cycle, starting 4 cycles after each acceptance; no response is 0.
- Busy stall with forced small pool:
  - Stimulus: `NUM_MEM_TAGS`=4, `MEM_LATENCY`=3, 4 back-to-back loads.
  - Response: the 4th load gets response 0 until tag 1 completes, then is accepted with response 1 on the cycle after completion.
- Reset mid-flight (run with and without the macro):
  - Stimulus: 3 loads outstanding, assert `reset` for 1 cycle.
  - Response: no completions follow; next load gets tag 1.
  - With the macro: response is 0 for 1024 cycles, then a load of any address returns 0.
